// File: rtl/fp_res_stage_40_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_res_stage_40_if
// Purpose  : Bundles the upstream and downstream handshake/data signals of the
//            fp_res_stage_40 result stage.
// Modports : slave  - the result stage itself
//            master - the environment (upstream producer + downstream consumer)
// Signals  : in_valid_40/in_ready_40, in_x_40, in_y_40, in_res_40 (upstream)
//            out_valid_40/out_ready_40, out_res_40, out_flags_40, out_cnt_40
// Revision : 1.0 - initial release
// ============================================================================
interface fp_res_stage_40_if #(
    parameter int CNT_W_40 = 16
);
    logic                in_valid_40;
    logic                in_ready_40;
    logic [31:0]         in_x_40;
    logic [31:0]         in_y_40;
    logic [31:0]         in_res_40;
    logic                out_valid_40;
    logic                out_ready_40;
    logic [31:0]         out_res_40;
    logic [3:0]          out_flags_40;
    logic [CNT_W_40-1:0] out_cnt_40;

    modport slave (
        input  in_valid_40, in_x_40, in_y_40, in_res_40, out_ready_40,
        output in_ready_40, out_valid_40, out_res_40, out_flags_40, out_cnt_40
    );

    modport master (
        output in_valid_40, in_x_40, in_y_40, in_res_40, out_ready_40,
        input  in_ready_40, out_valid_40, out_res_40, out_flags_40, out_cnt_40
    );
endinterface
`default_nettype wire

// File: rtl/fp_res_stage_40.sv
`default_nettype none
// ============================================================================
// Module   : fp_res_stage_40
// Purpose  : Result stage for a 32-bit IEEE 754 add/sub datapath. Applies
//            NaN/Inf/overflow/cancellation/underflow fixups to the raw adder
//            result and queues {flags,result} in a small FIFO behind a
//            valid/ready handshake.
// Ports    : clk_40 - clock, rising edge
//            rst_40 - asynchronous reset, active low
//            bus    - fp_res_stage_40_if.slave (operands, raw result, output
//                     result, flags {invalid,overflow,underflow,zero}, count)
// Revision : 1.0 - initial release
// ============================================================================
module fp_res_stage_40 #(
    parameter int          DEPTH_40 = 2,
    parameter int          CNT_W_40 = 16,
    parameter logic [31:0] QNAN_40  = 32'h7FC00000
) (
    input  wire logic          clk_40,
    input  wire logic          rst_40,
    fp_res_stage_40_if.slave   bus
);
    localparam int             PTR_W   = $clog2(DEPTH_40);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH_40);

    // ------------------------------------------------------------------
    // Operand classification
    // ------------------------------------------------------------------
    logic w_x_expff, w_y_expff, w_x_nan, w_y_nan, w_x_inf, w_y_inf;
    logic w_mag_eq, w_mag_zero, w_sgn_diff;

    assign w_x_expff  = (bus.in_x_40[30:23] == 8'hFF);
    assign w_y_expff  = (bus.in_y_40[30:23] == 8'hFF);
    assign w_x_nan    = w_x_expff && (bus.in_x_40[22:0] != 23'd0);
    assign w_y_nan    = w_y_expff && (bus.in_y_40[22:0] != 23'd0);
    assign w_x_inf    = w_x_expff && (bus.in_x_40[22:0] == 23'd0);
    assign w_y_inf    = w_y_expff && (bus.in_y_40[22:0] == 23'd0);
    assign w_mag_eq   = (bus.in_x_40[30:0] == bus.in_y_40[30:0]);
    assign w_mag_zero = (bus.in_x_40[30:0] == 31'd0);
    assign w_sgn_diff = bus.in_x_40[31] ^ bus.in_y_40[31];

    // ------------------------------------------------------------------
    // Fixup, evaluated in priority order
    // ------------------------------------------------------------------
    logic [31:0] w_res;
    logic [3:0]  w_flags;

    always_comb begin
        w_res   = bus.in_res_40;
        w_flags = 4'b0000;
        if (w_x_nan || w_y_nan) begin
            w_res   = QNAN_40;
            w_flags = 4'b1000;
        end else if (w_x_inf && w_y_inf && w_sgn_diff) begin
            w_res   = QNAN_40;
            w_flags = 4'b1000;
        end else if (w_x_inf) begin
            w_res   = bus.in_x_40;
        end else if (w_y_inf) begin
            w_res   = bus.in_y_40;
        end else if (w_mag_eq && w_mag_zero) begin
            // +0 + -0 rounds to +0; like-signed zeros keep their sign
            w_res   = w_sgn_diff ? 32'h0000_0000 : {bus.in_x_40[31], 31'd0};
            w_flags = 4'b0001;
        end else if (w_mag_eq && w_sgn_diff) begin
            w_res   = 32'h0000_0000;
            w_flags = 4'b0001;
        end else if (bus.in_res_40[30:23] == 8'hFF) begin
            w_res   = {bus.in_res_40[31], 8'hFF, 23'd0};
            w_flags = 4'b0100;
        end else if (bus.in_res_40[30:23] == 8'h00) begin
            // Denormals are flushed; a true zero also lands here
            w_res   = {bus.in_res_40[31], 31'd0};
            w_flags = 4'b0011;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [35:0]         r_mem [DEPTH_40];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic [CNT_W_40-1:0] r_cnt;
    logic                w_push;
    logic                w_pop;
    logic                w_valid;

    assign w_valid         = (r_count != '0);
    // Ready depends only on stored occupancy, never on out_ready_40
    assign bus.in_ready_40 = (r_count < C_DEPTH);
    assign w_push          = bus.in_valid_40 && bus.in_ready_40;
    assign w_pop           = w_valid && bus.out_ready_40;

    // Storage is not reset; occupancy alone decides what is visible
    always_ff @(posedge clk_40) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_flags, w_res};
        end
    end

    always_ff @(posedge clk_40 or negedge rst_40) begin
        if (!rst_40) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_cnt    <= r_cnt + CNT_W_40'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_valid_40 = w_valid;
    assign bus.out_res_40   = w_valid ? r_mem[r_rd_ptr][31:0]  : 32'd0;
    assign bus.out_flags_40 = w_valid ? r_mem[r_rd_ptr][35:32] : 4'd0;
    assign bus.out_cnt_40   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_res_stage_40.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_res_stage_40
// Purpose  : Directed self-checking bench for fp_res_stage_40. Inputs change
//            and outputs are observed on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_res_stage_40;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [15:0] exp_cnt;

    fp_res_stage_40_if #(.CNT_W_40(16)) bus();

    fp_res_stage_40 #(
        .DEPTH_40 (2),
        .CNT_W_40 (16),
        .QNAN_40  (32'h7FC00000)
    ) dut (
        .clk_40 (clk),
        .rst_40 (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r);
        bus.in_valid_40 = v;
        bus.in_x_40     = x;
        bus.in_y_40     = y;
        bus.in_res_40   = r;
    endtask

    // Present one operand set for one edge; returns at the falling edge after accept
    task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r);
        @(negedge clk);
        drive(1'b1, x, y, r);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset;
        bus.out_ready_40 = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #12;
        total++; if (bus.out_valid_40 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid_40); end
        total++; if (bus.out_res_40 !== 32'd0) begin bad++; $display("FAIL rst_res got=%h want=00000000", bus.out_res_40); end
        total++; if (bus.out_flags_40 !== 4'd0) begin bad++; $display("FAIL rst_flags got=%b want=0000", bus.out_flags_40); end
        total++; if (bus.out_cnt_40 !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", bus.out_cnt_40); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready_40 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready_40); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_passthrough;
        bus.out_ready_40 = 1'b1;
        apply(32'h3F800000, 32'h40000000, 32'h40400000);
        total++; if (bus.out_valid_40 !== 1'b1) begin bad++; $display("FAIL pass_valid got=%b want=1", bus.out_valid_40); end
        total++; if (bus.out_res_40 !== 32'h40400000) begin bad++; $display("FAIL pass_res got=%h want=40400000", bus.out_res_40); end
        total++; if (bus.out_flags_40 !== 4'b0000) begin bad++; $display("FAIL pass_flags got=%b want=0000", bus.out_flags_40); end
        @(negedge clk);
        exp_cnt++;
        total++; if (bus.out_cnt_40 !== exp_cnt) begin bad++; $display("FAIL pass_cnt got=%0d want=%0d", bus.out_cnt_40, exp_cnt); end
        total++; if (bus.out_valid_40 !== 1'b0) begin bad++; $display("FAIL pass_empty got=%b want=0", bus.out_valid_40); end
    endtask

    task automatic test_fixups;
        logic [31:0] tx [14];
        logic [31:0] ty [14];
        logic [31:0] tr [14];
        logic [31:0] er [14];
        logic [3:0]  ef [14];
        // NaN operands
        tx[0]  = 32'h7FC00001; ty[0]  = 32'h3F800000; tr[0]  = 32'h12345678; er[0]  = 32'h7FC00000; ef[0]  = 4'b1000;
        tx[1]  = 32'h00000001; ty[1]  = 32'hFFC00000; tr[1]  = 32'h40000000; er[1]  = 32'h7FC00000; ef[1]  = 4'b1000;
        tx[2]  = 32'h7F800000; ty[2]  = 32'h7F800001; tr[2]  = 32'h40000000; er[2]  = 32'h7FC00000; ef[2]  = 4'b1000;
        // Inf - Inf
        tx[3]  = 32'h7F800000; ty[3]  = 32'hFF800000; tr[3]  = 32'h40000000; er[3]  = 32'h7FC00000; ef[3]  = 4'b1000;
        // Single / like-signed Inf
        tx[4]  = 32'hFF800000; ty[4]  = 32'h3F800000; tr[4]  = 32'h40000000; er[4]  = 32'hFF800000; ef[4]  = 4'b0000;
        tx[5]  = 32'h3F800000; ty[5]  = 32'hFF800000; tr[5]  = 32'h40000000; er[5]  = 32'hFF800000; ef[5]  = 4'b0000;
        tx[6]  = 32'h7F800000; ty[6]  = 32'h7F800000; tr[6]  = 32'h40000000; er[6]  = 32'h7F800000; ef[6]  = 4'b0000;
        // Zeros
        tx[7]  = 32'h00000000; ty[7]  = 32'h80000000; tr[7]  = 32'h80000000; er[7]  = 32'h00000000; ef[7]  = 4'b0001;
        tx[8]  = 32'h80000000; ty[8]  = 32'h80000000; tr[8]  = 32'h40000000; er[8]  = 32'h80000000; ef[8]  = 4'b0001;
        // Exact cancellation
        tx[9]  = 32'h40490FDB; ty[9]  = 32'hC0490FDB; tr[9]  = 32'h3F800000; er[9]  = 32'h00000000; ef[9]  = 4'b0001;
        // Overflow, with and without sign
        tx[10] = 32'h7F7FFFFF; ty[10] = 32'h7F7FFFFF; tr[10] = 32'h7F800000; er[10] = 32'h7F800000; ef[10] = 4'b0100;
        tx[11] = 32'h3F800000; ty[11] = 32'h40000000; tr[11] = 32'hFF812345; er[11] = 32'hFF800000; ef[11] = 4'b0100;
        // Underflow flush
        tx[12] = 32'h00800000; ty[12] = 32'h80000001; tr[12] = 32'h00012345; er[12] = 32'h00000000; ef[12] = 4'b0011;
        tx[13] = 32'h00800001; ty[13] = 32'h80800000; tr[13] = 32'h80000001; er[13] = 32'h80000000; ef[13] = 4'b0011;
        bus.out_ready_40 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            apply(tx[i], ty[i], tr[i]);
            total++; if (bus.out_res_40 !== er[i]) begin bad++; $display("FAIL fix%0d_res got=%h want=%h", i, bus.out_res_40, er[i]); end
            total++; if (bus.out_flags_40 !== ef[i]) begin bad++; $display("FAIL fix%0d_flags got=%b want=%b", i, bus.out_flags_40, ef[i]); end
            @(negedge clk);
            exp_cnt++;
        end
        total++; if (bus.out_cnt_40 !== exp_cnt) begin bad++; $display("FAIL fix_cnt got=%0d want=%0d", bus.out_cnt_40, exp_cnt); end
    endtask

    task automatic test_backpressure;
        bus.out_ready_40 = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h3F800000, 32'h40000000, 32'h40400000);   // A -> 40400000/0000
        @(negedge clk);
        total++; if (bus.in_ready_40 !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b want=1", bus.in_ready_40); end
        drive(1'b1, 32'h00000001, 32'h00000002, 32'h00012345);   // B -> 00000000/0011
        @(negedge clk);
        total++; if (bus.in_ready_40 !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", bus.in_ready_40); end
        total++; if (bus.out_res_40 !== 32'h40400000) begin bad++; $display("FAIL bp_headA got=%h want=40400000", bus.out_res_40); end
        drive(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);   // C -> 7F800000/0100
        @(negedge clk);
        total++; if (bus.in_ready_40 !== 1'b0) begin bad++; $display("FAIL bp_held got=%b want=0", bus.in_ready_40); end
        total++; if (bus.out_res_40 !== 32'h40400000) begin bad++; $display("FAIL bp_stable got=%h want=40400000", bus.out_res_40); end
        bus.out_ready_40 = 1'b1;
        @(negedge clk);
        exp_cnt++;
        total++; if (bus.out_res_40 !== 32'h00000000 || bus.out_flags_40 !== 4'b0011) begin bad++; $display("FAIL bp_headB got=%h/%b want=00000000/0011", bus.out_res_40, bus.out_flags_40); end
        total++; if (bus.in_ready_40 !== 1'b1) begin bad++; $display("FAIL bp_ready2 got=%b want=1", bus.in_ready_40); end
        @(negedge clk);
        exp_cnt++;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        total++; if (bus.out_res_40 !== 32'h7F800000 || bus.out_flags_40 !== 4'b0100) begin bad++; $display("FAIL bp_headC got=%h/%b want=7F800000/0100", bus.out_res_40, bus.out_flags_40); end
        @(negedge clk);
        exp_cnt++;
        total++; if (bus.out_valid_40 !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", bus.out_valid_40); end
        total++; if (bus.out_cnt_40 !== exp_cnt) begin bad++; $display("FAIL bp_cnt got=%0d want=%0d", bus.out_cnt_40, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        bus.out_ready_40 = 1'b1;
        @(negedge clk);
        drive(1'b1, 32'h40000000, 32'h3F800000, 32'h40000000);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            d = 32'h40000000 + 32'(i - 1) * 32'h10;
            total++; if (bus.out_valid_40 !== 1'b1 || bus.in_ready_40 !== 1'b1) begin bad++; $display("FAIL b2b%0d_occ valid=%b ready=%b want=1/1", i, bus.out_valid_40, bus.in_ready_40); end
            total++; if (bus.out_res_40 !== d) begin bad++; $display("FAIL b2b%0d_res got=%h want=%h", i, bus.out_res_40, d); end
            drive(1'b1, 32'h40000000, 32'h3F800000, 32'h40000000 + 32'(i) * 32'h10);
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        total++; if (bus.out_res_40 !== 32'h400000A0) begin bad++; $display("FAIL b2b_last got=%h want=400000a0", bus.out_res_40); end
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd11;
        total++; if (bus.out_cnt_40 !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", bus.out_cnt_40, exp_cnt); end
    endtask

    task automatic test_async_reset;
        bus.out_ready_40 = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h3F800000, 32'h40000000, 32'h40400000);
        @(negedge clk);
        drive(1'b1, 32'h3F800000, 32'h40000000, 32'h40800000);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        total++; if (bus.out_valid_40 !== 1'b1 || bus.in_ready_40 !== 1'b0) begin bad++; $display("FAIL ar_full valid=%b ready=%b want=1/0", bus.out_valid_40, bus.in_ready_40); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid_40 !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", bus.out_valid_40); end
        total++; if (bus.out_res_40 !== 32'd0) begin bad++; $display("FAIL ar_res got=%h want=00000000", bus.out_res_40); end
        total++; if (bus.out_cnt_40 !== 16'd0) begin bad++; $display("FAIL ar_cnt got=%0d want=0", bus.out_cnt_40); end
        exp_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready_40 = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready_40 !== 1'b1 || bus.out_valid_40 !== 1'b0) begin bad++; $display("FAIL ar_post ready=%b valid=%b want=1/0", bus.in_ready_40, bus.out_valid_40); end
        apply(32'h3F800000, 32'h40000000, 32'h40A00000);
        total++; if (bus.out_res_40 !== 32'h40A00000) begin bad++; $display("FAIL ar_fresh got=%h want=40a00000", bus.out_res_40); end
        @(negedge clk);
        exp_cnt++;
        total++; if (bus.out_valid_40 !== 1'b0 || bus.out_cnt_40 !== exp_cnt) begin bad++; $display("FAIL ar_drain valid=%b cnt=%0d want=0/%0d", bus.out_valid_40, bus.out_cnt_40, exp_cnt); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_cnt = 16'd0;
        rst_n   = 1'b1;
        test_reset();
        test_passthrough();
        test_fixups();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
